muldiv_sched: RTL and testbench

- Controller that sequences the shared 32-cycle unsigned shift-add/shift-subtract multiply/divide engine (mode 0 = multu, mode 1 = divu; 64-bit output {hi, lo}) for the EX stage.
- Converts signed RV32M operands to magnitudes and launches the engine with a one-cycle valid pulse.
- Stalls the pipeline until the engine's one-cycle ready, then applies sign correction and presents one 32-bit result.
- Also handles divide-by-zero, signed overflow and pipeline flush.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_sched_sign_fix.sv | 31 +++
 rtl/muldiv_sched.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide scheduler.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} md_state_e;

  typedef enum logic [1:0] {CLS_UNS, CLS_SS, CLS_SU} sign_cls_e;

  typedef struct packed {
    md_op_e op;
    logic   a_neg;
    logic   b_neg;
  } req_info_t;

  localparam logic [31:0] XLEN_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // MUL is unsigned here: its low word is identical for any signedness.
  function automatic sign_cls_e sign_cls(md_op_e op);
    sign_cls_e c;
    case (op)
      MD_MULH, MD_DIV, MD_REM: c = CLS_SS;
      MD_MULHSU:               c = CLS_SU;
      default:                 c = CLS_UNS;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_sched_sign_fix.sv
// Combinational sign correction of the unsigned engine result into the final RV32M value.
module md_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  md_op_e              op,
  input  logic                a_neg,
  input  logic                b_neg,
  input  logic [2*XLEN-1:0]   raw,
  output logic [XLEN-1:0]     res
);

  logic              prod_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod_neg = (op == MD_MULHSU) ? a_neg : (a_neg ^ b_neg);
    prod     = prod_neg ? -raw : raw;
    quo      = (a_neg ^ b_neg) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    rem      = a_neg ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
    case (op)
      MD_MUL:                        res = raw[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               res = quo;
      default:                       res = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage sequencer for the shared multiply/divide engine.
// Optional result reuse of the last engine output when MULDIV_REUSE_EN is defined.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              md_valid,
  output logic              md_mode,
  output logic [XLEN-1:0]   md_in_a,
  output logic [XLEN-1:0]   md_in_b,
  input  logic              md_ready,
  input  logic [2*XLEN-1:0] md_out,
  output logic              timeout_err
);

  md_state_e         state_q, state_d;
  req_info_t         info_q, info_d;
  logic [XLEN-1:0]   in_a_q, in_a_d, in_b_q, in_b_d, resp_data_q, resp_data_d;
  logic              md_valid_q, md_valid_d, md_mode_q, md_mode_d;
  logic              resp_valid_q, resp_valid_d, tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Request decode: magnitudes, sign flags and early-out results.
  md_op_e            rop;
  sign_cls_e         rcls;
  logic              ra_neg, rb_neg, b_zero, ovf, wd_hit, idle;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res, fix_res;
  logic              hit;
  logic [2*XLEN-1:0] fix_raw;

  assign rop      = md_op_e'(req_op);
  assign rcls     = sign_cls(rop);
  assign ra_neg   = (rcls != CLS_UNS) && req_a[XLEN-1];
  assign rb_neg   = (rcls == CLS_SS) && req_b[XLEN-1];
  assign abs_a    = ra_neg ? -req_a : req_a;
  assign abs_b    = rb_neg ? -req_b : req_b;
  assign b_zero   = (req_b == '0);
  assign ovf      = ((rop == MD_DIV) || (rop == MD_REM)) && (req_a == INT_MIN) && (req_b == XLEN_ONES);
  assign spec_res = b_zero ? (rop[1] ? req_a : XLEN_ONES) : (rop[1] ? '0 : INT_MIN);
  assign wd_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign idle     = (state_q == IDLE);

  md_sign_fix #(.XLEN(XLEN)) u_fix (
    .op    (idle ? rop : info_q.op),
    .a_neg (idle ? ra_neg : info_q.a_neg),
    .b_neg (idle ? rb_neg : info_q.b_neg),
    .raw   (fix_raw),
    .res   (fix_res)
  );

`ifdef MULDIV_REUSE_EN
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            a_neg;
    logic            b_neg;
    sign_cls_e       cls;
    logic            mode;
  } key_t;

  logic              ck_vld_q, ck_vld_d;
  logic [2*XLEN-1:0] ck_raw_q, ck_raw_d;
  key_t              ck_key_q, ck_key_d, req_key;

  assign req_key = '{a: abs_a, b: abs_b, a_neg: ra_neg, b_neg: rb_neg, cls: rcls, mode: rop[2]};
  assign hit     = ck_vld_q && (ck_key_q == req_key);
  assign fix_raw = idle ? ck_raw_q : md_out;

  always_comb begin
    ck_vld_d = ck_vld_q;
    ck_raw_d = ck_raw_q;
    ck_key_d = ck_key_q;
    if (flush) begin
      ck_vld_d = 1'b0;
    end else if (state_q == WAIT && md_ready) begin
      ck_vld_d = 1'b1;
      ck_raw_d = md_out;
      ck_key_d = '{a: in_a_q, b: in_b_q, a_neg: info_q.a_neg, b_neg: info_q.b_neg,
                   cls: sign_cls(info_q.op), mode: md_mode_q};
    end else if ((state_q == WAIT || state_q == DRAIN) && wd_hit) begin
      ck_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_vld_q <= 1'b0;
      ck_raw_q <= '0;
      ck_key_q <= '0;
    end else begin
      ck_vld_q <= ck_vld_d;
      ck_raw_q <= ck_raw_d;
      ck_key_q <= ck_key_d;
    end
  end
`else
  assign hit     = 1'b0;
  assign fix_raw = md_out;
`endif

  always_comb begin
    state_d      = state_q;
    info_d       = info_q;
    in_a_d       = in_a_q;
    in_b_d       = in_b_q;
    md_mode_d    = md_mode_q;
    md_valid_d   = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    case (state_q)
      IDLE: if (req_valid && !flush) begin
        info_d = '{op: rop, a_neg: ra_neg, b_neg: rb_neg};
        if (rop[2] && (b_zero || ovf)) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = spec_res;
        end else if (hit) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = fix_res;
        end else begin
          state_d    = ISSUE;
          md_valid_d = 1'b1;
          md_mode_d  = rop[2];
          in_a_d     = abs_a;
          in_b_d     = abs_b;
          cnt_d      = '0;
        end
      end
      ISSUE: state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush) begin
          state_d = md_ready ? IDLE : DRAIN;
        end else if (md_ready) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = fix_res;
        end else if (wd_hit) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          tmo_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The engine cannot be aborted; wait out its result, still under the watchdog.
      DRAIN: begin
        if (md_ready) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      info_q       <= '0;
      in_a_q       <= '0;
      in_b_q       <= '0;
      md_mode_q    <= 1'b0;
      md_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      info_q       <= info_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      md_mode_q    <= md_mode_d;
      md_valid_q   <= md_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign stall       = req_valid && ((state_q == DRAIN) || ((state_q != DONE) && !flush));
  assign resp_valid  = resp_valid_q && !flush;
  assign resp_data   = resp_data_q;
  assign md_valid    = md_valid_q;
  assign md_mode     = md_mode_q;
  assign md_in_a     = in_a_q;
  assign md_in_b     = in_b_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with a behavioural 33-cycle multiply/divide engine.
module tb_muldiv_sched;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, md_ready = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [63:0] md_out = '0;
  logic        stall, resp_valid, md_valid, md_mode, timeout_err;
  logic [31:0] resp_data, md_in_a, md_in_b;

  always #5 clk = ~clk;

  muldiv_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data), .md_valid(md_valid),
    .md_mode(md_mode), .md_in_a(md_in_a), .md_in_b(md_in_b),
    .md_ready(md_ready), .md_out(md_out), .timeout_err(timeout_err)
  );

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Engine: ready pulse 33 cycles after the start pulse, result computed at launch.
  bit eng_en = 1'b1;
  int eng_cnt = 0;
  always @(negedge clk) begin
    md_ready = 1'b0;
    if (!rst_n) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) md_ready = 1'b1;
      end
      if (md_valid && eng_en) begin
        eng_cnt = 33;
        md_out  = md_mode ? {md_in_a % md_in_b, md_in_a / md_in_b} : 64'(md_in_a) * 64'(md_in_b);
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit issue,
                        input logic [31:0] ia, input logic [31:0] ib);
    int lat = 0, pulses = 0, stall_bad = 0;
    logic [31:0] got = '0, cia = '0, cib = '0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1;
    if (!stall) stall_bad++;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (md_valid) begin pulses++; cia = md_in_a; cib = md_in_b; end
      if (resp_valid) begin
        lat = i; got = resp_data;
        if (stall) stall_bad++;
      end else if (!stall) stall_bad++;
    end
    req_valid = 1'b0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " data"}, got, exp);
    chk({nm, " md_valid pulses"}, pulses, issue ? 1 : 0);
    chk({nm, " stall"}, stall_bad, 0);
    if (issue) begin
      chk({nm, " md_in_a"}, cia, ia);
      chk({nm, " md_in_b"}, cib, ib);
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
    bit          issue;
    logic [31:0] ia, ib;
  } vec_t;

  vec_t v[14];

  initial begin
    int lat, pulses, stall_bad;
    logic [31:0] got;

    v[0]  = '{"mulh_m2x3",   MD_MULH,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 35, 1, 32'd2,        32'd3};
    v[1]  = '{"div_m7_2",    MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 1, 32'd7,        32'd2};
    v[2]  = '{"mul_m2x3",    MD_MUL,    32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 35, 1, 32'hFFFFFFFE, 32'd3};
    v[3]  = '{"rem_m7_2",    MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 1, 32'd7,        32'd2};
    v[4]  = '{"divu_by0",    MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, 32'd0,        32'd0};
    v[5]  = '{"rem_by0",     MD_REM,    32'd5,        32'd0,        32'd5,        1,  0, 32'd0,        32'd0};
    v[6]  = '{"div_ovf",     MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, 32'd0,        32'd0};
    v[7]  = '{"rem_ovf",     MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0, 32'd0,        32'd0};
    v[8]  = '{"mulhsu_m1",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 1, 32'd1,        32'hFFFFFFFF};
    v[9]  = '{"mulhu_max",   MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    v[10] = '{"divu_100_7",  MD_DIVU,   32'd100,      32'd7,        32'd14,       35, 1, 32'd100,      32'd7};
    v[11] = '{"remu_100_9",  MD_REMU,   32'd100,      32'd9,        32'd1,        35, 1, 32'd100,      32'd9};
    v[12] = '{"div_7_m2",    MD_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35, 1, 32'd7,        32'd2};
    v[13] = '{"mulh_intmin", MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35, 1, 32'h80000000, 32'h80000000};

    #1;
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset md_in_a", md_in_a, 32'd0);
    chk("reset md_in_b", md_in_b, 32'd0);
    chk("reset flags", {27'd0, stall, resp_valid, md_valid, md_mode, timeout_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 14; k++)
      run_op(v[k].nm, v[k].op, v[k].a, v[k].b, v[k].exp, v[k].lat, v[k].issue, v[k].ia, v[k].ib);

`ifdef MULDIV_REUSE_EN
    run_op("div_100_7", MD_DIV, 32'd100, 32'd7, 32'd14, 35, 1, 32'd100, 32'd7);
    run_op("rem_reuse", MD_REM, 32'd100, 32'd7, 32'd2, 1, 0, 32'd0, 32'd0);
`endif

    // Flush ten cycles into WAIT, then a MUL waits out the drain.
    req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd1000; req_b = 32'd3;
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    chk("flush stall", stall, 1'b0);
    chk("flush resp_valid", resp_valid, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; req_op = MD_MUL; req_a = 32'd3; req_b = 32'd4;
    #1;
    chk("drain stall", stall, 1'b1);
    lat = 0; pulses = 0; stall_bad = 0; got = '0;
    for (int i = 1; i <= 80 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (md_valid) pulses++;
      if (resp_valid) begin lat = i; got = resp_data; end
      else if (!stall) stall_bad++;
    end
    req_valid = 1'b0;
    chk("post-drain latency", lat, 57);
    chk("post-drain mul data", got, 32'd12);
    chk("post-drain md_valid pulses", pulses, 1);
    chk("drain stall held", stall_bad, 0);
    @(posedge clk); #1;

    // Engine never answers: watchdog fires after 40 WAIT cycles.
    chk("timeout_err before", timeout_err, 1'b0);
    eng_en = 1'b0;
    run_op("watchdog", MD_MULHU, 32'd5, 32'd6, 32'd0, 42, 1, 32'd5, 32'd6);
    eng_en = 1'b1;
    chk("timeout_err sticky", timeout_err, 1'b1);

    // Reset in the middle of an engine op.
    req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd50; req_b = 32'd5;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("midop reset flags", {27'd0, stall, resp_valid, md_valid, md_mode, timeout_err}, 32'd0);
    chk("midop reset md_in_a", md_in_a, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_after_reset", MD_MUL, 32'd3, 32'd4, 32'd12, 35, 1, 32'd3, 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global time limit: got no finish expected finish");
    $fatal(1);
  end

endmodule
